// File: rtl/cpu_control_fsm_pkg.sv
// -----------------------------------------------------------------------------
// cpu_control_fsm_pkg
// Shared definitions for the multicycle CPU control unit: the controller state
// enum, the opcode/funct constants it decodes, and the encodings of the mux
// selects and ALU operation it produces.
// Used by cpu_control_fsm and cpu_ctrl_decode via import cpu_control_fsm_pkg::*.
// -----------------------------------------------------------------------------
package cpu_control_fsm_pkg;

   // Controller states; HALT is only reachable when CTRL_ILLEGAL_TRAP_EN is defined
   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      EX_R    = 4'd2,
      EX_I    = 4'd3,
      ADDR    = 4'd4,
      MEM_RD  = 4'd5,
      MEM_WR  = 4'd6,
      WB_MEM  = 4'd7,
      WB_ALU  = 4'd8,
      BRANCH  = 4'd9,
      JUMP    = 4'd10,
      JAL     = 4'd11,
      JR      = 4'd12,
      HALT    = 4'd13
   } state_t;

   // Opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type function codes (IR[5:0])
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   // ALU operation codes
   localparam logic [2:0] ALU_ADD  = 3'd0;
   localparam logic [2:0] ALU_SUB  = 3'd1;
   localparam logic [2:0] ALU_XOR  = 3'd2;
   localparam logic [2:0] ALU_SLT  = 3'd3;

   // Next-PC source
   localparam logic [1:0] PC_ALU    = 2'd0;
   localparam logic [1:0] PC_ALUOUT = 2'd1;
   localparam logic [1:0] PC_JUMP   = 2'd2;
   localparam logic [1:0] PC_REG    = 2'd3;

   // Register-file write data source
   localparam logic [1:0] WD_ALUOUT = 2'd0;
   localparam logic [1:0] WD_MEM    = 2'd1;
   localparam logic [1:0] WD_PC     = 2'd2;

   // ALU B operand source
   localparam logic [1:0] B_REG     = 2'd0;
   localparam logic [1:0] B_FOUR    = 2'd1;
   localparam logic [1:0] B_EXT     = 2'd2;
   localparam logic [1:0] B_EXT_SH2 = 2'd3;

   // Register-file destination select
   localparam logic [1:0] RD_RT     = 2'd0;
   localparam logic [1:0] RD_RD     = 2'd1;
   localparam logic [1:0] RD_RA     = 2'd2;

   // ALU operation for a supported R-type funct; unknown functs fall back to ADD
   function automatic logic [2:0] rtype_alu_op(input logic [5:0] funct);
      case (funct)
         FN_SUB:  return ALU_SUB;
         FN_SLT:  return ALU_SLT;
         default: return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/cpu_control_fsm_decode.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_decode
// Combinational instruction classifier used in the DECODE state: maps the
// opcode/funct pair to the state that executes it.
// Ports:
//   opcode  in  6  IR[31:26]
//   funct   in  6  IR[5:0]
//   target  out    execute state for a recognised instruction (FETCH otherwise)
//   legal   out 1  instruction is one the controller implements
// -----------------------------------------------------------------------------
module cpu_ctrl_decode
   import cpu_control_fsm_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output state_t     target,
   output logic       legal
);

   // Classify the instruction; anything unrecognised reports legal=0 and the
   // caller decides whether that means trap or NOP
   always_comb begin
      target = FETCH;
      legal  = 1'b1;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADD, FN_SUB, FN_SLT: target = EX_R;
               FN_JR:                  target = JR;
               default:                legal  = 1'b0;
            endcase
         end
         OP_ADDI, OP_XORI: target = EX_I;
         OP_LW, OP_SW:     target = ADDR;
         OP_BNE:           target = BRANCH;
         OP_J:             target = JUMP;
         OP_JAL:           target = JAL;
         default:          legal  = 1'b0;
      endcase
   end

endmodule

// File: rtl/cpu_control_fsm.sv
// -----------------------------------------------------------------------------
// cpu_control_fsm
// Multicycle CPU controller. Only the state is registered; every control output
// is decoded from the state (FETCH also looks at mem_ready, BRANCH at zero, and
// the EX/WB states at the held IR fields).
// Optional feature: define CTRL_ILLEGAL_TRAP_EN to send undecoded instructions
// to HALT (sticky illegal_op) instead of treating them as NOPs.
// Ports:
//   clk, reset (async, active-high)
//   opcode[5:0], funct[5:0]  IR fields
//   zero                     ALU zero flag
//   mem_ready                memory access completes this cycle
//   pc_we, ir_we, mem_we, iord, reg_we, alu_a_sel, ext_sel   1-bit controls
//   reg_dst, wd_sel, alu_b_sel, pc_src                       2-bit selects
//   alu_op[ALUOP_W-1:0]      ALU operation
//   state[STATE_W-1:0]       debug view of the current state
//   illegal_op               set while trapped in HALT
// -----------------------------------------------------------------------------
module cpu_control_fsm
   import cpu_control_fsm_pkg::*;
#(
   parameter int STATE_W = 4,
   parameter int ALUOP_W = 3
)(
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         opcode,
   input  logic [5:0]         funct,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               pc_we,
   output logic               ir_we,
   output logic               mem_we,
   output logic               iord,
   output logic               reg_we,
   output logic               alu_a_sel,
   output logic               ext_sel,
   output logic [1:0]         reg_dst,
   output logic [1:0]         wd_sel,
   output logic [1:0]         alu_b_sel,
   output logic [1:0]         pc_src,
   output logic [ALUOP_W-1:0] alu_op,
   output logic [STATE_W-1:0] state,
   output logic               illegal_op
);

   state_t     cur_state;
   state_t     nxt_state;
   state_t     dec_target;
   logic       dec_legal;
   logic [2:0] alu_op_c;

   cpu_ctrl_decode u_decode (
      .opcode (opcode),
      .funct  (funct),
      .target (dec_target),
      .legal  (dec_legal)
   );

   // State register; reset drops straight back to FETCH even mid-instruction
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_state <= FETCH;
      end else begin
         cur_state <= nxt_state;
      end
   end

   // Next-state logic; memory states wait on mem_ready, everything else
   // advances every cycle
   always_comb begin
      nxt_state = cur_state;
      case (cur_state)
         FETCH:   if (mem_ready) nxt_state = DECODE;
         DECODE: begin
            if (dec_legal) begin
               nxt_state = dec_target;
            end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
               nxt_state = HALT;
`else
               nxt_state = FETCH;
`endif
            end
         end
         EX_R, EX_I:  nxt_state = WB_ALU;
         ADDR:        nxt_state = (opcode == OP_SW) ? MEM_WR : MEM_RD;
         MEM_RD:      if (mem_ready) nxt_state = WB_MEM;
         MEM_WR:      if (mem_ready) nxt_state = FETCH;
         WB_ALU, WB_MEM, BRANCH, JUMP, JAL, JR: nxt_state = FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
         HALT:        nxt_state = HALT;
`else
         HALT:        nxt_state = FETCH;
`endif
         default:     nxt_state = FETCH;
      endcase
   end

   // Output table; everything defaults to 0 and each state raises only what it
   // needs. WB_ALU picks rd vs rt from the opcode, which the IR still holds.
   always_comb begin
      pc_we     = 1'b0;
      ir_we     = 1'b0;
      mem_we    = 1'b0;
      iord      = 1'b0;
      reg_we    = 1'b0;
      alu_a_sel = 1'b0;
      ext_sel   = 1'b0;
      reg_dst   = RD_RT;
      wd_sel    = WD_ALUOUT;
      alu_b_sel = B_REG;
      pc_src    = PC_ALU;
      alu_op_c  = ALU_ADD;
      case (cur_state)
         FETCH: begin
            alu_b_sel = B_FOUR;
            ir_we     = mem_ready;
            pc_we     = mem_ready;
         end
         DECODE: begin
            alu_b_sel = B_EXT_SH2;
            ext_sel   = 1'b1;
         end
         EX_R: begin
            alu_a_sel = 1'b1;
            alu_op_c  = rtype_alu_op(funct);
         end
         EX_I: begin
            alu_a_sel = 1'b1;
            alu_b_sel = B_EXT;
            ext_sel   = (opcode == OP_ADDI);
            alu_op_c  = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
         end
         WB_ALU: begin
            reg_we  = 1'b1;
            reg_dst = (opcode == OP_RTYPE) ? RD_RD : RD_RT;
         end
         ADDR: begin
            alu_a_sel = 1'b1;
            alu_b_sel = B_EXT;
            ext_sel   = 1'b1;
         end
         MEM_RD: iord = 1'b1;
         MEM_WR: begin
            iord   = 1'b1;
            mem_we = 1'b1;
         end
         WB_MEM: begin
            reg_we = 1'b1;
            wd_sel = WD_MEM;
         end
         BRANCH: begin
            alu_a_sel = 1'b1;
            alu_op_c  = ALU_SUB;
            pc_src    = PC_ALUOUT;
            pc_we     = ~zero;
         end
         JUMP: begin
            pc_src = PC_JUMP;
            pc_we  = 1'b1;
         end
         JAL: begin
            pc_src  = PC_JUMP;
            pc_we   = 1'b1;
            reg_we  = 1'b1;
            reg_dst = RD_RA;
            wd_sel  = WD_PC;
         end
         JR: begin
            pc_src = PC_REG;
            pc_we  = 1'b1;
         end
         default: ;
      endcase
   end

   assign alu_op = ALUOP_W'(alu_op_c);
   assign state  = STATE_W'(cur_state);

   // HALT is never left without reset, so being in it is already sticky
`ifdef CTRL_ILLEGAL_TRAP_EN
   assign illegal_op = (cur_state == HALT);
`else
   assign illegal_op = 1'b0;
`endif

endmodule
